ccu_conflict_sched: RTL

Address-conflict scheduler for the CCU ingress. It sits between the per-core AXI/ACE request ports and the CCU, and decides when each port's AW and AR requests may be forwarded. A request is held back while its address window overlaps an in-flight transaction from another port. Requests that arrive in the same cycle with overlapping windows are resolved by round-robin priority, with optional starvation protection. The block only drives gating and grant signals; the parent module ANDs `*_gnt_o` into the forwarded valid and ready signals.

---
 rtl/ccu_conflict_sched.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ccu_conflict_sched.sv
// ccu_conflict_sched: holds back AW/AR requests whose address windows
// overlap in-flight traffic of other ports. Macro: CCU_CONFLICT_SCHED_STARVE_EN.
module ccu_conflict_sched #(
  parameter int unsigned NoPorts      = 2,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned StallLimit   = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NoPorts-1:0]                     aw_valid_i,
  input  logic [NoPorts-1:0][AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [NoPorts-1:0][7:0]                aw_len_i,
  input  logic [NoPorts-1:0][2:0]                aw_size_i,
  output logic [NoPorts-1:0]                     aw_gnt_o,
  input  logic [NoPorts-1:0]                     aw_hs_i,
  input  logic [NoPorts-1:0]                     b_hs_i,
  input  logic [NoPorts-1:0]                     ar_valid_i,
  input  logic [NoPorts-1:0][AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [NoPorts-1:0][7:0]                ar_len_i,
  input  logic [NoPorts-1:0][2:0]                ar_size_i,
  output logic [NoPorts-1:0]                     ar_gnt_o,
  input  logic [NoPorts-1:0]                     ar_hs_i,
  input  logic [NoPorts-1:0]                     r_last_hs_i,
  output logic [NoPorts-1:0]                     starve_o
);
  localparam int unsigned AW = AxiAddrWidth;
  localparam int unsigned PW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESP} slot_e;
  typedef logic [AW-1:0] addr_t;

  function automatic addr_t win_start(addr_t a, logic [2:0] sz);
    return a & ~((addr_t'(1) << sz) - addr_t'(1));
  endfunction

  function automatic addr_t win_end(addr_t s, logic [7:0] len,
                                    logic [2:0] sz);
    logic [AW:0] bytes;
    logic [AW:0] sum;
    bytes = ((AW+1)'(len) + (AW+1)'(1)) << sz;
    sum   = {1'b0, s} + bytes - (AW+1)'(1);
    return sum[AW] ? '1 : sum[AW-1:0];
  endfunction

  function automatic logic ovl(addr_t sa, addr_t ea, addr_t sb, addr_t eb);
    return (sa <= eb) && (sb <= ea);
  endfunction

  slot_e w_st_q [NoPorts];
  slot_e w_st_d [NoPorts];
  slot_e r_st_q [NoPorts];
  slot_e r_st_d [NoPorts];
  addr_t w_s_q [NoPorts];
  addr_t w_e_q [NoPorts];
  addr_t r_s_q [NoPorts];
  addr_t r_e_q [NoPorts];
  addr_t w_s_d [NoPorts];
  addr_t w_e_d [NoPorts];
  addr_t r_s_d [NoPorts];
  addr_t r_e_d [NoPorts];
  addr_t aw_s [NoPorts];
  addr_t aw_e [NoPorts];
  addr_t ar_s [NoPorts];
  addr_t ar_e [NoPorts];

  logic [PW-1:0]      rr_q, rr_d, head;
  logic [NoPorts-1:0] aw_cand, ar_cand;
  logic [NoPorts-1:0] aw_win, ar_win;
  logic [NoPorts-1:0] aw_gnt_q, aw_gnt_d;
  logic [NoPorts-1:0] ar_gnt_q, ar_gnt_d;

`ifdef CCU_CONFLICT_SCHED_STARVE_EN
  localparam int unsigned CW = $clog2(StallLimit + 1);
  logic [CW-1:0]      cnt_q [NoPorts];
  logic [CW-1:0]      cnt_d [NoPorts];
  logic [NoPorts-1:0] starve_q, starve_d;
  logic               starve_any;

  // Lowest-index starving port takes the head of the visit order.
  always_comb begin
    head       = rr_q;
    starve_any = |starve_q;
    for (int i = int'(NoPorts) - 1; i >= 0; i--)
      if (starve_q[i]) head = PW'(i);
  end

  // Saturating stall counters; any grant to the port clears them.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      cnt_d[p] = cnt_q[p];
      if (aw_win[p] || ar_win[p])
        cnt_d[p] = '0;
      else if (((aw_valid_i[p] && w_st_q[p] == IDLE) ||
                (ar_valid_i[p] && r_st_q[p] == IDLE)) &&
               cnt_q[p] < CW'(StallLimit))
        cnt_d[p] = cnt_q[p] + CW'(1);
      starve_d[p] = cnt_d[p] >= CW'(StallLimit);
    end
  end

  // Stall counter and starving flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      for (int p = 0; p < NoPorts; p++) cnt_q[p] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int p = 0; p < NoPorts; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign starve_o = starve_q;
`else
  assign head = rr_q;
  // StallLimit is at least 1, so this is constant zero.
  assign starve_o = {NoPorts{StallLimit == 0}};
`endif

  // Windows of the incoming requests.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      aw_s[p] = win_start(aw_addr_i[p], aw_size_i[p]);
      aw_e[p] = win_end(aw_s[p], aw_len_i[p], aw_size_i[p]);
      ar_s[p] = win_start(ar_addr_i[p], ar_size_i[p]);
      ar_e[p] = win_end(ar_s[p], ar_len_i[p], ar_size_i[p]);
    end
  end

  // Candidates: idle, valid, and clear of other ports' reserved windows.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      aw_cand[p] = aw_valid_i[p] && w_st_q[p] == IDLE;
      ar_cand[p] = ar_valid_i[p] && r_st_q[p] == IDLE;
      for (int q = 0; q < NoPorts; q++) begin
        if (q != p && w_st_q[q] != IDLE) begin
          if (ovl(aw_s[p], aw_e[p], w_s_q[q], w_e_q[q])) aw_cand[p] = 1'b0;
          if (ovl(ar_s[p], ar_e[p], w_s_q[q], w_e_q[q])) ar_cand[p] = 1'b0;
        end
        if (q != p && r_st_q[q] != IDLE &&
            ovl(aw_s[p], aw_e[p], r_s_q[q], r_e_q[q]))
          aw_cand[p] = 1'b0;
      end
    end
  end

  // Ordered arbitration from head; AW before AR within a port.
  always_comb begin
    int  p;
    int  last;
    logic any;
    logic ok;
    aw_win = '0;
    ar_win = '0;
    p      = 0;
    last   = 0;
    any    = 1'b0;
    ok     = 1'b0;
    for (int k = 0; k < NoPorts; k++) begin
      p  = (int'(head) + k) % int'(NoPorts);
      ok = aw_cand[p];
      for (int q = 0; q < NoPorts; q++) begin
        if (q != p && aw_win[q] && ovl(aw_s[p], aw_e[p], aw_s[q], aw_e[q]))
          ok = 1'b0;
        if (q != p && ar_win[q] && ovl(aw_s[p], aw_e[p], ar_s[q], ar_e[q]))
          ok = 1'b0;
      end
`ifdef CCU_CONFLICT_SCHED_STARVE_EN
      if (starve_any && p != int'(head)) begin
        if (aw_valid_i[head] && w_st_q[head] == IDLE &&
            ovl(aw_s[p], aw_e[p], aw_s[head], aw_e[head]))
          ok = 1'b0;
        if (ar_valid_i[head] && r_st_q[head] == IDLE &&
            ovl(aw_s[p], aw_e[p], ar_s[head], ar_e[head]))
          ok = 1'b0;
      end
`endif
      if (ok) begin
        aw_win[p] = 1'b1;
        last      = p;
        any       = 1'b1;
      end
      ok = ar_cand[p];
      for (int q = 0; q < NoPorts; q++)
        if (q != p && aw_win[q] && ovl(ar_s[p], ar_e[p], aw_s[q], aw_e[q]))
          ok = 1'b0;
`ifdef CCU_CONFLICT_SCHED_STARVE_EN
      if (starve_any && p != int'(head) &&
          aw_valid_i[head] && w_st_q[head] == IDLE &&
          ovl(ar_s[p], ar_e[p], aw_s[head], aw_e[head]))
        ok = 1'b0;
`endif
      if (ok) begin
        ar_win[p] = 1'b1;
        last      = p;
        any       = 1'b1;
      end
    end
    rr_d = any ? PW'((last + 1) % int'(NoPorts)) : rr_q;
  end

  // Slot FSM next state and window capture.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      w_st_d[p] = w_st_q[p];
      r_st_d[p] = r_st_q[p];
      w_s_d[p]  = w_s_q[p];
      w_e_d[p]  = w_e_q[p];
      r_s_d[p]  = r_s_q[p];
      r_e_d[p]  = r_e_q[p];
      unique case (w_st_q[p])
        IDLE: if (aw_win[p]) begin
          w_st_d[p] = GRANT;
          w_s_d[p]  = aw_s[p];
          w_e_d[p]  = aw_e[p];
        end
        GRANT:     if (aw_hs_i[p]) w_st_d[p] = WAIT_RESP;
        WAIT_RESP: if (b_hs_i[p])  w_st_d[p] = IDLE;
        default:   w_st_d[p] = IDLE;
      endcase
      unique case (r_st_q[p])
        IDLE: if (ar_win[p]) begin
          r_st_d[p] = GRANT;
          r_s_d[p]  = ar_s[p];
          r_e_d[p]  = ar_e[p];
        end
        GRANT:     if (ar_hs_i[p])     r_st_d[p] = WAIT_RESP;
        WAIT_RESP: if (r_last_hs_i[p]) r_st_d[p] = IDLE;
        default:   r_st_d[p] = IDLE;
      endcase
      aw_gnt_d[p] = w_st_d[p] == GRANT;
      ar_gnt_d[p] = r_st_d[p] == GRANT;
    end
  end

  // Slot state, windows, pointer and grant registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      aw_gnt_q <= '0;
      ar_gnt_q <= '0;
      for (int p = 0; p < NoPorts; p++) begin
        w_st_q[p] <= IDLE;
        r_st_q[p] <= IDLE;
        w_s_q[p]  <= '0;
        w_e_q[p]  <= '0;
        r_s_q[p]  <= '0;
        r_e_q[p]  <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      aw_gnt_q <= aw_gnt_d;
      ar_gnt_q <= ar_gnt_d;
      for (int p = 0; p < NoPorts; p++) begin
        w_st_q[p] <= w_st_d[p];
        r_st_q[p] <= r_st_d[p];
        w_s_q[p]  <= w_s_d[p];
        w_e_q[p]  <= w_e_d[p];
        r_s_q[p]  <= r_s_d[p];
        r_e_q[p]  <= r_e_d[p];
      end
    end
  end

  assign aw_gnt_o = aw_gnt_q;
  assign ar_gnt_o = ar_gnt_q;

endmodule
